// File: rtl/rvfi_retire_serializer_pkg.sv
// Shared definitions for the RVFI retirement serializer and the packers/unpackers around it.
// The record layout below is the contract between the core-side packer and the checker-side unpacker.
package rvfi_retire_serializer_pkg;

  localparam int DEF_NRET    = 2;
  localparam int DEF_PKT_W   = 288;
  localparam int DEF_ORDER_W = 8;
  localparam int DEF_DEPTH   = 8;

  localparam int INSN_LSB      = 0;
  localparam int INSN_W        = 32;
  localparam int RS1_ADDR_LSB  = INSN_LSB + INSN_W;
  localparam int RS1_ADDR_W    = 5;
  localparam int RS2_ADDR_LSB  = RS1_ADDR_LSB + RS1_ADDR_W;
  localparam int RS2_ADDR_W    = 5;
  localparam int RD_ADDR_LSB   = RS2_ADDR_LSB + RS2_ADDR_W;
  localparam int RD_ADDR_W     = 5;
  localparam int RS1_RDATA_LSB = RD_ADDR_LSB + RD_ADDR_W;
  localparam int RS1_RDATA_W   = 32;
  localparam int RD_WDATA_LSB  = RS1_RDATA_LSB + RS1_RDATA_W;
  localparam int RD_WDATA_W    = 32;
  localparam int PC_RDATA_LSB  = RD_WDATA_LSB + RD_WDATA_W;
  localparam int PC_RDATA_W    = 32;
  localparam int PC_WDATA_LSB  = PC_RDATA_LSB + PC_RDATA_W;
  localparam int PC_WDATA_W    = 32;
  localparam int TRAP_LSB      = PC_WDATA_LSB + PC_WDATA_W;
  localparam int TRAP_W        = 1;
  localparam int MEM_ADDR_LSB  = TRAP_LSB + TRAP_W;
  localparam int MEM_ADDR_W    = 32;
  localparam int MEM_RMASK_LSB = MEM_ADDR_LSB + MEM_ADDR_W;
  localparam int MEM_RMASK_W   = 4;
  localparam int MEM_WMASK_LSB = MEM_RMASK_LSB + MEM_RMASK_W;
  localparam int MEM_WMASK_W   = 4;
  localparam int MEM_RDATA_LSB = MEM_WMASK_LSB + MEM_WMASK_W;
  localparam int MEM_RDATA_W   = 32;
  localparam int MEM_WDATA_LSB = MEM_RDATA_LSB + MEM_RDATA_W;
  localparam int MEM_WDATA_W   = 32;
  localparam int HALT_LSB      = MEM_WDATA_LSB + MEM_WDATA_W;
  localparam int INTR_LSB      = HALT_LSB + 1;
  localparam int MODE_LSB      = INTR_LSB + 1;
  localparam int MODE_W        = 2;
  localparam int IXL_LSB       = MODE_LSB + MODE_W;
  localparam int IXL_W         = 2;
  localparam int RSVD_LSB      = IXL_LSB + IXL_W;
  localparam int RSVD_W        = 2;
  localparam int REC_END       = RSVD_LSB + RSVD_W;

  typedef struct packed {
    logic [1:0]  ixl;
    logic [1:0]  mode;
    logic        intr;
    logic        halt;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic [3:0]  memWmask;
    logic [3:0]  memRmask;
    logic [31:0] memAddr;
    logic        trap;
    logic [31:0] pcWdata;
    logic [31:0] pcRdata;
    logic [31:0] rdWdata;
    logic [31:0] rs1Rdata;
    logic [4:0]  rdAddr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rs1Addr;
    logic [31:0] insn;
  } rvfi_rec_t;

  // The reserved bits are dropped on unpack; everything else maps one-to-one.
  function automatic rvfi_rec_t unpackRec(input logic [DEF_PKT_W-1:0] pkt);
    rvfi_rec_t rec;
    rec.insn     = pkt[INSN_LSB      +: INSN_W];
    rec.rs1Addr  = pkt[RS1_ADDR_LSB  +: RS1_ADDR_W];
    rec.rs2Addr  = pkt[RS2_ADDR_LSB  +: RS2_ADDR_W];
    rec.rdAddr   = pkt[RD_ADDR_LSB   +: RD_ADDR_W];
    rec.rs1Rdata = pkt[RS1_RDATA_LSB +: RS1_RDATA_W];
    rec.rdWdata  = pkt[RD_WDATA_LSB  +: RD_WDATA_W];
    rec.pcRdata  = pkt[PC_RDATA_LSB  +: PC_RDATA_W];
    rec.pcWdata  = pkt[PC_WDATA_LSB  +: PC_WDATA_W];
    rec.trap     = pkt[TRAP_LSB];
    rec.memAddr  = pkt[MEM_ADDR_LSB  +: MEM_ADDR_W];
    rec.memRmask = pkt[MEM_RMASK_LSB +: MEM_RMASK_W];
    rec.memWmask = pkt[MEM_WMASK_LSB +: MEM_WMASK_W];
    rec.memRdata = pkt[MEM_RDATA_LSB +: MEM_RDATA_W];
    rec.memWdata = pkt[MEM_WDATA_LSB +: MEM_WDATA_W];
    rec.halt     = pkt[HALT_LSB];
    rec.intr     = pkt[INTR_LSB];
    rec.mode     = pkt[MODE_LSB      +: MODE_W];
    rec.ixl      = pkt[IXL_LSB       +: IXL_W];
    return rec;
  endfunction

endpackage

// File: rtl/rvfi_retire_serializer_if.sv
// Retirement bus between a multi-retire core (master) and the serializer (slave),
// including the single-channel output stream toward the checker.
interface rvfi_retire_serializer_if
  import rvfi_retire_serializer_pkg::*;
#(
  parameter int NRET    = DEF_NRET,
  parameter int PKT_W   = DEF_PKT_W,
  parameter int ORDER_W = DEF_ORDER_W
);

  logic [NRET-1:0]         in_valid;
  logic [NRET*ORDER_W-1:0] in_order;
  logic [NRET*PKT_W-1:0]   in_pkt;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [ORDER_W-1:0]      out_order;
  logic [PKT_W-1:0]        out_pkt;

  modport master (
    output in_valid, in_order, in_pkt, out_ready,
    input  in_ready, out_valid, out_order, out_pkt
  );

  modport slave (
    input  in_valid, in_order, in_pkt, out_ready,
    output in_ready, out_valid, out_order, out_pkt
  );

endinterface

// File: rtl/rvfi_retire_serializer_compact.sv
// Prefix popcount over the enabled retirement channels: each valid channel gets its
// write offset (number of older valid channels) and the total count of writes.
module rvfi_retire_serializer_compact
  import rvfi_retire_serializer_pkg::*;
#(
  parameter int NRET = DEF_NRET,
  parameter int OW   = $clog2(NRET + 1)
) (
  input  logic [NRET-1:0]         i_valid,
  input  logic                    i_enable,
  output logic [NRET-1:0]         o_validMasked,
  output logic [NRET-1:0][OW-1:0] o_offset,
  output logic [OW-1:0]           o_count
);

  logic [OW-1:0] w_run;

  always_comb begin
    o_validMasked = i_valid & {NRET{i_enable}};
    o_offset      = '0;
    w_run         = '0;
    for (int i = 0; i < NRET; i++) begin
      o_offset[i] = w_run;
      w_run       = w_run + OW'(o_validMasked[i]);
    end
    o_count = w_run;
  end

endmodule

// File: rtl/rvfi_retire_serializer.sv
// Multi-retire RVFI to single in-order retirement stream, with a burst FIFO and
// sticky overflow / order-gap flags intended for formal assertions.
module rvfi_retire_serializer
  import rvfi_retire_serializer_pkg::*;
#(
  parameter int NRET    = DEF_NRET,
  parameter int PKT_W   = DEF_PKT_W,
  parameter int ORDER_W = DEF_ORDER_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_enable,
  rvfi_retire_serializer_if.slave    bus,
  output logic                       o_overflow,
  output logic                       o_orderErr,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(NRET + 1);

  logic [ORDER_W-1:0] r_memOrder [DEPTH];
  logic [PKT_W-1:0]   r_memPkt   [DEPTH];
  logic [AW-1:0]      r_wrPtr;
  logic [AW-1:0]      r_rdPtr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic               r_orderErr;
  logic               r_firstPop;
  logic [ORDER_W-1:0] r_lastOrder;

  logic [NRET-1:0]         w_validMasked;
  logic [NRET-1:0][OW-1:0] w_offset;
  logic [OW-1:0]           w_n;
  logic [NRET-1:0][AW-1:0] w_wrIdx;
  logic [CW-1:0]           w_nExt;
  logic [CW-1:0]           w_free;
  logic [CW-1:0]           w_countNext;
  logic                    w_pop;
  logic                    w_drop;
  logic                    w_write;

  rvfi_retire_serializer_compact #(
    .NRET (NRET),
    .OW   (OW)
  ) u_compact (
    .i_valid       (bus.in_valid),
    .i_enable      (i_enable),
    .o_validMasked (w_validMasked),
    .o_offset      (w_offset),
    .o_count       (w_n)
  );

  // A popped slot is reusable in the same cycle; a cycle either fits entirely or is dropped.
  always_comb begin
    w_pop       = (r_count != '0) && bus.out_ready;
    w_nExt      = CW'(w_n);
    w_free      = CW'(DEPTH) - r_count + CW'(w_pop);
    w_drop      = (w_nExt > w_free);
    w_write     = !w_drop;
    w_countNext = r_count + (w_write ? w_nExt : '0) - CW'(w_pop);
    for (int i = 0; i < NRET; i++) begin
      w_wrIdx[i] = r_wrPtr + AW'(w_offset[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_orderErr  <= 1'b0;
      r_firstPop  <= 1'b1;
      r_lastOrder <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_memOrder[k] <= '0;
        r_memPkt[k]   <= '0;
      end
    end else begin
      if (w_write) begin
        for (int i = 0; i < NRET; i++) begin
          if (w_validMasked[i]) begin
            r_memOrder[w_wrIdx[i]] <= bus.in_order[i*ORDER_W +: ORDER_W];
            r_memPkt[w_wrIdx[i]]   <= bus.in_pkt[i*PKT_W +: PKT_W];
          end
        end
        r_wrPtr <= r_wrPtr + AW'(w_n);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_countNext;
      // The first pop after reset only seeds the sequence; later pops must be contiguous.
      if (w_pop) begin
        r_rdPtr     <= r_rdPtr + AW'(1);
        r_firstPop  <= 1'b0;
        r_lastOrder <= bus.out_order;
        if (!r_firstPop && (bus.out_order != r_lastOrder + ORDER_W'(1))) begin
          r_orderErr <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = (r_count <= CW'(DEPTH - NRET));
  assign bus.out_valid = (r_count != '0);
  assign bus.out_order = r_memOrder[r_rdPtr];
  assign bus.out_pkt   = r_memPkt[r_rdPtr];
  assign o_overflow    = r_overflow;
  assign o_orderErr    = r_orderErr;
  assign o_count       = r_count;

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Directed bench for rvfi_retire_serializer: a reference queue of expected retirements
// plus a small occupancy/flag model, checked every cycle and at the key scenarios.
module tb_rvfi_retire_serializer;

  localparam int NRET    = 2;
  localparam int PKT_W   = 288;
  localparam int ORDER_W = 8;
  localparam int DEPTH   = 8;
  localparam int VW      = 288;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       overflow;
  logic       orderErr;
  logic [3:0] count;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]       sbOrder [$];
  logic [PKT_W-1:0] sbPkt   [$];
  int               mCount;
  bit               mOverflow;
  bit               mOrderErr;
  bit               mFirst;
  logic [7:0]       mLast;

  rvfi_retire_serializer_if #(.NRET(NRET), .PKT_W(PKT_W), .ORDER_W(ORDER_W)) bus ();

  rvfi_retire_serializer #(
    .NRET    (NRET),
    .PKT_W   (PKT_W),
    .ORDER_W (ORDER_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (enable),
    .bus        (bus),
    .o_overflow (overflow),
    .o_orderErr (orderErr),
    .o_count    (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [VW-1:0] observed, input logic [VW-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [PKT_W-1:0] makePkt(input logic [7:0] ord);
    logic [PKT_W-1:0] p;
    for (int k = 0; k < PKT_W / 32; k++) p[k*32 +: 32] = $urandom();
    p[7:0] = ord;
    return p;
  endfunction

  // Drives one cycle, checks the current registered state against the model, then advances the model.
  task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] v,
                               input logic [7:0] o0, input logic [7:0] o1, input logic rdy);
    logic [PKT_W-1:0] p0;
    logic [PKT_W-1:0] p1;
    logic [7:0]       ord;
    int               n;
    int               free;
    bit               pop;
    p0 = makePkt(o0);
    p1 = makePkt(o1);
    reset         = rst;
    enable        = en;
    bus.in_valid  = v;
    bus.in_order  = {o1, o0};
    bus.in_pkt    = {p1, p0};
    bus.out_ready = rdy;

    checkOutput("count", VW'(count), VW'(mCount));
    checkOutput("out_valid", VW'(bus.out_valid), VW'(mCount != 0));
    checkOutput("in_ready", VW'(bus.in_ready), VW'((DEPTH - mCount) >= NRET));
    checkOutput("overflow", VW'(overflow), VW'(mOverflow));
    checkOutput("order_err", VW'(orderErr), VW'(mOrderErr));
    if (mCount != 0 && sbOrder.size() > 0) begin
      checkOutput("head_order", VW'(bus.out_order), VW'(sbOrder[0]));
      checkOutput("head_pkt", VW'(bus.out_pkt), VW'(sbPkt[0]));
    end

    pop = !rst && rdy && (mCount != 0);
    if (rst) begin
      sbOrder.delete();
      sbPkt.delete();
      mCount    = 0;
      mOverflow = 1'b0;
      mOrderErr = 1'b0;
      mFirst    = 1'b1;
      mLast     = '0;
    end else begin
      if (pop) begin
        ord = sbOrder.pop_front();
        void'(sbPkt.pop_front());
        if (!mFirst && ord != mLast + 8'd1) mOrderErr = 1'b1;
        mFirst = 1'b0;
        mLast  = ord;
      end
      n    = en ? (int'(v[0]) + int'(v[1])) : 0;
      free = DEPTH - mCount + (pop ? 1 : 0);
      if (n > free) begin
        mOverflow = 1'b1;
      end else begin
        if (en && v[0]) begin sbOrder.push_back(o0); sbPkt.push_back(p0); end
        if (en && v[1]) begin sbOrder.push_back(o1); sbPkt.push_back(p1); end
        mCount += n;
      end
      if (pop) mCount--;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    mCount = 0; mOverflow = 1'b0; mOrderErr = 1'b0; mFirst = 1'b1; mLast = '0;
    reset = 1'b1; enable = 1'b1;
    bus.in_valid = '0; bus.in_order = '0; bus.in_pkt = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_count", VW'(count), VW'(0));
    checkOutput("rst_out_valid", VW'(bus.out_valid), VW'(0));
    checkOutput("rst_in_ready", VW'(bus.in_ready), VW'(1));
    checkOutput("rst_overflow", VW'(overflow), VW'(0));
    checkOutput("rst_order_err", VW'(orderErr), VW'(0));
    checkOutput("rst_out_order", VW'(bus.out_order), VW'(0));
    checkOutput("rst_out_pkt", VW'(bus.out_pkt), VW'(0));

    $display("[TB] dual retire, streaming out");
    applyStimulus(0, 1, 2'b11, 8'd4, 8'd5, 1);
    checkOutput("t1_head4", VW'(bus.out_order), VW'(4));
    applyStimulus(0, 1, 2'b00, 8'd0, 8'd0, 1);
    checkOutput("t1_head5", VW'(bus.out_order), VW'(5));
    applyStimulus(0, 1, 2'b00, 8'd0, 8'd0, 1);
    checkOutput("t1_empty", VW'(bus.out_valid), VW'(0));
    checkOutput("t1_order_err", VW'(orderErr), VW'(0));

    $display("[TB] sparse valid");
    applyStimulus(1, 1, 2'b00, 8'd0, 8'd0, 0);
    applyStimulus(0, 1, 2'b10, 8'd0, 8'd7, 0);
    checkOutput("t2_count", VW'(count), VW'(1));
    checkOutput("t2_out_order", VW'(bus.out_order), VW'(7));
    checkOutput("t2_slot0", VW'(dut.r_memOrder[0]), VW'(7));
    applyStimulus(0, 1, 2'b00, 8'd0, 8'd0, 1);
    checkOutput("t2_drained", VW'(bus.out_valid), VW'(0));

    $display("[TB] fill and overflow");
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 2'b11, 8'(8 + 2*k), 8'(9 + 2*k), 0);
    checkOutput("t3_full_count", VW'(count), VW'(8));
    checkOutput("t3_full_in_ready", VW'(bus.in_ready), VW'(0));
    checkOutput("t3_no_overflow_yet", VW'(overflow), VW'(0));
    applyStimulus(0, 1, 2'b11, 8'd16, 8'd17, 0);
    checkOutput("t3_overflow", VW'(overflow), VW'(1));
    checkOutput("t3_count_held", VW'(count), VW'(8));
    applyStimulus(1, 1, 2'b11, 8'd16, 8'd17, 0);
    checkOutput("t3_rst_count", VW'(count), VW'(0));
    checkOutput("t3_rst_overflow", VW'(overflow), VW'(0));
    checkOutput("t3_rst_out_valid", VW'(bus.out_valid), VW'(0));

    $display("[TB] push with pop near full");
    applyStimulus(0, 1, 2'b11, 8'd20, 8'd21, 0);
    applyStimulus(0, 1, 2'b11, 8'd22, 8'd23, 0);
    applyStimulus(0, 1, 2'b11, 8'd24, 8'd25, 0);
    applyStimulus(0, 1, 2'b01, 8'd26, 8'd0, 0);
    checkOutput("t4_count7", VW'(count), VW'(7));
    applyStimulus(0, 1, 2'b01, 8'd27, 8'd0, 1);
    checkOutput("t4_count7_again", VW'(count), VW'(7));
    checkOutput("t4_no_overflow_a", VW'(overflow), VW'(0));
    applyStimulus(0, 1, 2'b11, 8'd28, 8'd29, 1);
    checkOutput("t4_count8", VW'(count), VW'(8));
    checkOutput("t4_no_overflow_b", VW'(overflow), VW'(0));
    repeat (8) applyStimulus(0, 1, 2'b00, 8'd0, 8'd0, 1);
    checkOutput("t4_drained", VW'(bus.out_valid), VW'(0));
    checkOutput("t4_order_err", VW'(orderErr), VW'(0));

    $display("[TB] order wrap and gap");
    applyStimulus(1, 1, 2'b00, 8'd0, 8'd0, 0);
    applyStimulus(0, 1, 2'b11, 8'd254, 8'd255, 0);
    applyStimulus(0, 1, 2'b11, 8'd0, 8'd1, 0);
    applyStimulus(0, 1, 2'b11, 8'd2, 8'd3, 0);
    applyStimulus(0, 1, 2'b01, 8'd5, 8'd0, 0);
    repeat (6) applyStimulus(0, 1, 2'b00, 8'd0, 8'd0, 1);
    checkOutput("t5_wrap_ok", VW'(orderErr), VW'(0));
    applyStimulus(0, 1, 2'b00, 8'd0, 8'd0, 1);
    checkOutput("t5_gap", VW'(orderErr), VW'(1));
    applyStimulus(0, 1, 2'b01, 8'd6, 8'd0, 1);
    applyStimulus(0, 1, 2'b00, 8'd0, 8'd0, 1);
    checkOutput("t5_sticky", VW'(orderErr), VW'(1));

    $display("[TB] reset mid-burst and enable gating");
    applyStimulus(1, 1, 2'b00, 8'd0, 8'd0, 0);
    applyStimulus(0, 1, 2'b11, 8'd40, 8'd41, 0);
    applyStimulus(0, 1, 2'b11, 8'd42, 8'd43, 0);
    applyStimulus(0, 1, 2'b01, 8'd44, 8'd0, 0);
    checkOutput("t6_count5", VW'(count), VW'(5));
    applyStimulus(1, 1, 2'b11, 8'd45, 8'd46, 0);
    checkOutput("t6_rst_count", VW'(count), VW'(0));
    checkOutput("t6_rst_out_valid", VW'(bus.out_valid), VW'(0));
    checkOutput("t6_rst_overflow", VW'(overflow), VW'(0));
    checkOutput("t6_rst_order_err", VW'(orderErr), VW'(0));
    applyStimulus(0, 1, 2'b01, 8'd50, 8'd0, 0);
    applyStimulus(0, 0, 2'b11, 8'd51, 8'd52, 0);
    checkOutput("t6_enable_off", VW'(count), VW'(1));
    applyStimulus(0, 1, 2'b00, 8'd0, 8'd0, 1);
    checkOutput("t6_final_count", VW'(count), VW'(0));
    checkOutput("t6_final_order_err", VW'(orderErr), VW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_serializer.md
# rvfi_retire_serializer

Serializes up to NRET RVFI retirements per cycle from a multi-retire core into a single in-order retirement stream for one single-channel instruction checker. Sits between the core's RVFI port and a checker instance built with one channel. Buffers bursts in a FIFO, presents one retirement per cycle under ready/valid, and flags buffer overflow and order-sequence gaps as sticky errors for formal assertions.

## Interface
- NRET, 2: retirement channels on the input side.
- PKT_W, 288: width of one packed retirement record (insn, rs/rd addrs, pcs, rdata, trap, mem fields), excluding order.
- ORDER_W, 8: width of the rvfi_order field per channel.
- DEPTH, 8: FIFO entries; power of two, >= NRET.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, inputs are ignored (no writes); pops continue.
- in_valid  in  NRET  per-channel retirement valid; bit i = channel i.
- in_order  in  NRET*ORDER_W  per-channel order, channel i at [i*ORDER_W +: ORDER_W].
- in_pkt  in  NRET*PKT_W  per-channel packed record, channel i at [i*PKT_W +: PKT_W].
- in_ready  out  1  high when free entries >= NRET; informational, for use as an environment assumption.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts head this cycle.
- out_order  out  ORDER_W  order of head entry.
- out_pkt  out  PKT_W  record of head entry.
- overflow  out  1  sticky: a cycle's retirements were dropped.
- order_err  out  1  sticky: popped order was not previous popped order + 1.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Channel age: lower index is older within a cycle. Valid bits may be sparse (e.g. 2'b10 legal).
- Write: n = popcount(in_valid & {NRET{enable}}). Valid channels compacted in ascending index order and written to wr_ptr, wr_ptr+1, … (mod DEPTH).
- Pop: when out_valid && out_ready, head entry removed, rd_ptr+1 mod DEPTH.
- Space check: free = DEPTH - count + pop. If n > free, the whole cycle's n retirements are dropped (none written), overflow set. Partial writes never occur.
- Simultaneous push and pop: pop's slot counts as free in the same cycle; count_next = count + n_written - pop.
- Order check on every pop: first pop after reset loads last_order with no check; each later pop requires out_order == last_order + 1 mod 2^ORDER_W (255 -> 0 legal at ORDER_W=8), else order_err set. last_order updates on every pop.
- Dropped entries are not checked; a gap after overflow also sets order_err (expected).
- Sticky flags cleared only by reset.

## Timing
- Reset values: out_valid 0, count 0, in_ready 1, overflow 0, order_err 0, out_order/out_pkt 0 (storage reset), pointers 0, first-pop flag set.
- Latency: retirement at cycle t appears at output no earlier than t+1; no input-to-output bypass.
- out_order/out_pkt driven from registered storage at rd_ptr; stable while out_valid && !out_ready.
- in_ready, out_valid, count are functions of registered state only (no combinational path from in_valid or out_ready).
- Reset asserted mid-burst: all entries discarded next cycle; inputs in the reset cycle are not written.

## Structure
- Shared package rvfi_serial_pkg: default PKT_W, field offsets within the packed record (insn, rs1/rs2/rd addr, pre/post pc, rdata, trap, mem addr/masks/data), so the packer at the core side and unpacker at the checker side agree.
- One sub-module: rvfi_retire_compact — combinational prefix-popcount that maps valid channel i to write offset and outputs n.
- Top holds storage array, pointers, count, flags.

## Test plan
- NRET=2, DEPTH=8, in_valid=2'b11 orders 4,5 at cycle 1, out_ready=1 -> out_order 4 at cycle 2, 5 at cycle 3, out_valid 0 at cycle 4, order_err 0.
- Sparse in_valid=2'b10 order 7 -> single entry written at slot 0, count 1, out_order 7.
- out_ready=0, four cycles of 2'b11 -> count 8, in_ready 0; fifth 2'b11 -> dropped, overflow 1, count stays 8.
- count 7, out_ready=1, in_valid=2'b01 -> count stays 7 (push and pop), no overflow; with in_valid=2'b11 at count 7 and pop -> count 8, no overflow.
- Pops with orders 254, 255, 0 -> order_err 0; pops 3 then 5 -> order_err 1 and stays 1 until reset.
- reset high with count 5 -> next cycle count 0, out_valid 0, overflow 0; enable=0 with in_valid=2'b11 -> count unchanged.
